// File: rtl/kernel_ram_ctrl_pkg.sv
// Shared types and default sizing for the kernel RAM sequencer.
package kernel_ram_ctrl_pkg;

    localparam int          DEF_WEIGHT_DATA_WIDTH = 64;
    localparam logic [31:0] DEF_WEIGHT_BASE_ADDR  = 32'h4000_0000;
    localparam int          DEF_KERNEL_NUM        = 1024;
    localparam int          DEF_ULTRA_RAM_NUM     = 8;
    localparam int          DEF_OUT_FIFO_DEPTH    = 4;

    localparam int ROW_W   = DEF_WEIGHT_DATA_WIDTH * DEF_ULTRA_RAM_NUM;
    localparam int KADDR_W = $clog2(DEF_KERNEL_NUM);
    localparam int BANK_W  = $clog2(DEF_ULTRA_RAM_NUM);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/kernel_row_fifo.sv
// Output row FIFO: synchronous, same-cycle push/pop, exposes occupancy.
module kernel_row_fifo #(
    parameter  int pDEPTH = 4,
    parameter  int pWIDTH = 512,
    localparam int PW     = (pDEPTH > 1) ? $clog2(pDEPTH) : 1,
    localparam int CW     = $clog2(pDEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [pWIDTH-1:0] push_data_i,
    input  logic              pop_i,
    output logic [pWIDTH-1:0] pop_data_o,
    output logic              empty_o,
    output logic [CW-1:0]     count_o
);

    logic [pWIDTH-1:0] mem_q [pDEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(pDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage needs no reset; occupancy gates everything downstream.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/kernel_ram_ctrl.sv
// Kernel RAM sequencer: weight stream -> RAM write port, RAM rows -> conv engine.
// state | meaning
// IDLE  | waiting for a validated load_start / rd_start
// LOAD  | accepting weight beats, one RAM write per beat
// READ  | issuing row reads while FIFO space allows
// DRAIN | all rows issued, waiting for the last-row handshake
module kernel_ram_ctrl
    import kernel_ram_ctrl_pkg::*;
#(
    parameter  int          pWEIGHT_DATA_WIDTH = DEF_WEIGHT_DATA_WIDTH,
    parameter  logic [31:0] pWEIGHT_BASE_ADDR  = DEF_WEIGHT_BASE_ADDR,
    parameter  int          pKERNEL_NUM        = DEF_KERNEL_NUM,
    parameter  int          pULTRA_RAM_NUM     = DEF_ULTRA_RAM_NUM,
    parameter  int          pOUT_FIFO_DEPTH    = DEF_OUT_FIFO_DEPTH,
    localparam int          KW = $clog2(pKERNEL_NUM),
    localparam int          LW = KW + 1,
    localparam int          VW = KW + 2,
    localparam int          RW = pWEIGHT_DATA_WIDTH * pULTRA_RAM_NUM,
    localparam int          BW = (pULTRA_RAM_NUM > 1) ? $clog2(pULTRA_RAM_NUM) : 1,
    localparam int          CW = $clog2(pOUT_FIFO_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_start,
    input  logic [LW-1:0]                 load_len,
    input  logic                          s_wvalid,
    output logic                          s_wready,
    input  logic [pWEIGHT_DATA_WIDTH-1:0] s_wdata,
    input  logic                          rd_start,
    input  logic [KW-1:0]                 rd_base,
    input  logic [LW-1:0]                 rd_len,
    output logic                          wr_en,
    output logic [31:0]                   weight_addr,
    output logic [pWEIGHT_DATA_WIDTH-1:0] weight_data,
    output logic [KW-1:0]                 kernel_addr,
    input  logic [RW-1:0]                 kernel_data,
    output logic                          m_kvalid,
    input  logic                          m_kready,
    output logic [RW-1:0]                 m_kdata,
    output logic                          m_klast,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    state_e                        state_q, state_d;
    logic [LW-1:0]                 row_q, row_d;
    logic [BW-1:0]                 bank_q, bank_d;
    logic [LW-1:0]                 len_q, len_d;
    logic                          wr_en_q, wr_en_d;
    logic [31:0]                   waddr_q, waddr_d;
    logic [pWEIGHT_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [KW-1:0]                 kaddr_q, kaddr_d;
    logic [LW-1:0]                 issue_cnt_q, issue_cnt_d;
    logic [LW-1:0]                 out_cnt_q, out_cnt_d;
    logic                          inflight_q, inflight_d;
    logic                          done_q, done_d;
    logic                          err_q, err_d;

    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic [RW-1:0] fifo_dout;
    logic          load_bad, rd_bad, beat_acc, issue, pop_hs, last_hs;

    assign load_bad = (load_len == '0) || ({1'b0, load_len} > VW'(pKERNEL_NUM));
    assign rd_bad   = (rd_len == '0) ||
                      (({2'b00, rd_base} + {1'b0, rd_len}) > VW'(pKERNEL_NUM));

    assign beat_acc = (state_q == S_LOAD) && s_wvalid;
    // Count the row already in the RAM pipe so a full FIFO never gets overrun.
    assign issue    = (state_q == S_READ) &&
                      ((32'(fifo_cnt) + 32'(inflight_q)) < 32'(pOUT_FIFO_DEPTH));
    assign pop_hs   = m_kvalid && m_kready;
    assign last_hs  = pop_hs && m_klast;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        bank_d      = bank_q;
        len_d       = len_q;
        wr_en_d     = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        kaddr_d     = kaddr_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = pop_hs ? out_cnt_q + LW'(1) : out_cnt_q;
        inflight_d  = issue;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    if (load_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                        len_d   = load_len;
                        row_d   = '0;
                        bank_d  = '0;
                    end
                end else if (rd_start) begin
                    if (rd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = S_READ;
                        len_d       = rd_len;
                        kaddr_d     = rd_base;
                        issue_cnt_d = '0;
                        out_cnt_d   = '0;
                    end
                end
            end
            S_LOAD: begin
                if (beat_acc) begin
                    wr_en_d = 1'b1;
                    wdata_d = s_wdata;
                    waddr_d = pWEIGHT_BASE_ADDR + 32'(row_q);
                    if (bank_q == BW'(pULTRA_RAM_NUM - 1)) begin
                        bank_d = '0;
                        row_d  = row_q + LW'(1);
                        if (row_q == len_q - LW'(1)) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        bank_d = bank_q + BW'(1);
                    end
                end
            end
            S_READ: begin
                if (issue) begin
                    kaddr_d     = kaddr_q + KW'(1);
                    issue_cnt_d = issue_cnt_q + LW'(1);
                    if (issue_cnt_q == len_q - LW'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_hs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            bank_q      <= '0;
            len_q       <= '0;
            wr_en_q     <= 1'b0;
            waddr_q     <= pWEIGHT_BASE_ADDR;
            wdata_q     <= '0;
            kaddr_q     <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            bank_q      <= bank_d;
            len_q       <= len_d;
            wr_en_q     <= wr_en_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            kaddr_q     <= kaddr_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            inflight_q  <= inflight_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    kernel_row_fifo #(
        .pDEPTH (pOUT_FIFO_DEPTH),
        .pWIDTH (RW)
    ) u_row_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (kernel_data),
        .pop_i       (pop_hs),
        .pop_data_o  (fifo_dout),
        .empty_o     (fifo_empty),
        .count_o     (fifo_cnt)
    );

    assign s_wready    = (state_q == S_LOAD);
    assign wr_en       = wr_en_q;
    assign weight_addr = waddr_q;
    assign weight_data = wdata_q;
    assign kernel_addr = kaddr_q;
    assign m_kvalid    = !fifo_empty;
    assign m_kdata     = m_kvalid ? fifo_dout : '0;
    assign m_klast     = m_kvalid && (out_cnt_q == len_q - LW'(1));
    assign busy        = (state_q != S_IDLE);
    // A load finishes with its registered write; a read finishes on the last handshake.
    assign done        = done_q || ((state_q == S_DRAIN) && last_hs);
    assign err         = err_q;

endmodule

// File: tb/tb_kernel_ram_ctrl.sv
// Directed + randomized bench for kernel_ram_ctrl with a bank-pointer RAM stub.
module tb_kernel_ram_ctrl;

    localparam int          DW = 64, NB = 8, KN = 1024, RW = DW * NB;
    localparam int          KW = 10, LW = 11, DEPTH = 4;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start, s_wvalid, s_wready, rd_start;
    logic [LW-1:0] load_len, rd_len;
    logic [DW-1:0] s_wdata, weight_data;
    logic [KW-1:0] rd_base, kernel_addr;
    logic          wr_en, m_kvalid, m_kready, m_klast, busy, done, err;
    logic [31:0]   weight_addr;
    logic [RW-1:0] kernel_data, m_kdata;

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] model [KN];

    kernel_ram_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_len(load_len),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
        .wr_en(wr_en), .weight_addr(weight_addr), .weight_data(weight_data),
        .kernel_addr(kernel_addr), .kernel_data(kernel_data),
        .m_kvalid(m_kvalid), .m_kready(m_kready), .m_kdata(m_kdata), .m_klast(m_klast),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] dflt(input int r);
        logic [RW-1:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = (32'(r) * 32'h0101_0101) ^ (32'(k) * 32'h9E37_79B9);
        return v;
    endfunction

    // RAM stub: auto-advancing bank pointer on writes, 1-cycle read, read blanked on write cycles.
    logic [RW-1:0] ram [KN];
    bit            ram_ready;
    logic [2:0]    bptr;
    logic [KW-1:0] widx;
    assign widx = KW'(weight_addr - BASE);

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < KN; i++) ram[i] <= dflt(i);
            ram_ready <= 1'b1;
        end else if (wr_en) begin
            ram[widx][int'(bptr)*DW +: DW] <= weight_data;
        end
        kernel_data <= wr_en ? '0 : ram[kernel_addr];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     bptr <= '0;
        else if (wr_en) bptr <= bptr + 3'd1;
    end

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int len, input bit toggle, input bit with_rd);
        logic [DW-1:0] d[$];
        int beats, sent, got, cyc;
        bit acc, prev_acc;
        beats = len * NB; sent = 0; got = 0; cyc = 0; prev_acc = 0;
        for (int i = 0; i < beats; i++) d.push_back({$urandom, $urandom});
        load_len = LW'(len); load_start = 1'b1;
        rd_start = with_rd; rd_base = '0; rd_len = LW'(1);
        tick();
        load_start = 1'b0; rd_start = 1'b0;
        chk("ld_busy", busy, 1);
        chk("ld_no_err", err, 0);
        while (got < beats && cyc < 400) begin
            s_wvalid = (sent < beats) && (!toggle || (cyc % 2 == 0));
            s_wdata  = (sent < beats) ? d[sent] : '0;
            #1;
            chk("ld_wr_en", wr_en, prev_acc);
            if (prev_acc) begin
                chk("ld_wdata", weight_data, d[got]);
                chk("ld_waddr", weight_addr, BASE + 32'(got / NB));
                chk("ld_done", done, got == beats - 1);
                got++;
            end else begin
                chk("ld_no_done", done, 0);
            end
            chk("ld_wready", s_wready, sent < beats);
            acc = s_wvalid && s_wready;
            if (acc) sent++;
            prev_acc = acc;
            @(posedge clk);
            #1;
            cyc++;
        end
        s_wvalid = 1'b0;
        chk("ld_complete", got, beats);
        chk("ld_idle", busy, 0);
        chk("ld_wr_off", wr_en, 0);
        for (int r = 0; r < len; r++)
            for (int b = 0; b < NB; b++) model[r][b*DW +: DW] = d[r*NB + b];
    endtask

    task automatic do_read(input int base, input int len, input int pct, input bit strict);
        int idx, cyc, issued;
        bit fin, pv, pr, hs;
        logic [RW-1:0] pd;
        logic pl;
        idx = 0; cyc = 1; fin = 0; pv = 0; pr = 0; pd = '0; pl = 0;
        rd_base = KW'(base); rd_len = LW'(len); rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("rd_busy", busy, 1);
        while (!fin && cyc < 400) begin
            m_kready = ($urandom_range(99) < pct);
            #1;
            issued = int'(kernel_addr) - base;
            chk("rd_occupancy", (issued - idx) <= DEPTH, 1);
            chk("rd_wr_off", wr_en, 0);
            if (strict) begin
                if (cyc <= len) chk("rd_kaddr", kernel_addr, base + cyc - 1);
                chk("rd_kvalid_timing", m_kvalid, (cyc >= 3) && (cyc < 3 + len));
            end
            if (pv && !pr) begin
                chk("rd_stall_valid", m_kvalid, 1);
                chk("rd_stall_data", m_kdata, pd);
                chk("rd_stall_last", m_klast, pl);
            end
            if (m_kvalid) begin
                chk("rd_data", m_kdata, model[base + idx]);
                chk("rd_last", m_klast, idx == len - 1);
            end
            hs = m_kvalid && m_kready;
            chk("rd_done", done, hs && (idx == len - 1));
            if (hs) begin
                if (idx == len - 1) fin = 1;
                idx++;
            end
            pv = m_kvalid; pr = m_kready; pd = m_kdata; pl = m_klast;
            @(posedge clk);
            #1;
            cyc++;
        end
        m_kready = 1'b0;
        chk("rd_complete", fin, 1);
        chk("rd_idle", busy, 0);
    endtask

    task automatic reject(input bit is_load, input int len, input int base);
        if (is_load) begin
            load_len = LW'(len); load_start = 1'b1;
        end else begin
            rd_len = LW'(len); rd_base = KW'(base); rd_start = 1'b1;
        end
        tick();
        load_start = 1'b0; rd_start = 1'b0;
        chk("rej_err", err, 1);
        chk("rej_busy", busy, 0);
        tick();
        chk("rej_err_pulse", err, 0);
        chk("rej_busy_after", busy, 0);
    endtask

    initial begin
        int delivered, n;
        for (int i = 0; i < KN; i++) model[i] = dflt(i);
        rst_n = 1'b0; load_start = 0; load_len = '0; s_wvalid = 0; s_wdata = '0;
        rd_start = 0; rd_base = '0; rd_len = '0; m_kready = 0;
        repeat (3) tick();
        chk("rst_waddr", weight_addr, BASE);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_kvalid", m_kvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wready", s_wready, 0);
        rst_n = 1'b1;
        tick();

        do_load(2, 1'b0, 1'b0);
        do_load(1, 1'b1, 1'b0);
        do_read(5, 4, 100, 1'b1);
        do_read(300, 10, 50, 1'b0);
        do_read(0, 2, 60, 1'b0);

        reject(1'b0, 5, 1020);
        reject(1'b1, 0, 0);
        reject(1'b1, KN + 1, 0);
        reject(1'b0, 0, 3);
        do_read(1020, 4, 100, 1'b1);

        do_load(1, 1'b0, 1'b1);

        rd_base = KW'(100); rd_len = LW'(10); rd_start = 1'b1; m_kready = 1'b1;
        tick();
        rd_start = 1'b0;
        delivered = 0; n = 0;
        while (delivered < 2 && n < 20) begin
            #1;
            if (m_kvalid && m_kready) delivered++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_mid_rows", delivered, 2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_kvalid", m_kvalid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        tick();
        chk("rst_hold_kvalid", m_kvalid, 0);
        chk("rst_hold_done", done, 0);
        rst_n = 1'b1; m_kready = 1'b0;
        tick();
        chk("rst_after_done", done, 0);
        do_read(100, 10, 100, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kernel_ram_ctrl.md
Name: kernel_ram_ctrl

Overview:
- Sequencer for the kernel RAM.
- Loads weights from a valid/ready weight stream into the RAM's banks by driving its write port (wr_en, weight_addr, weight_data).
- Streams kernel rows back out to the convolution engine through a valid/ready interface with full backpressure.
- Load and read phases are mutually exclusive because the RAM suppresses its read output on write cycles; this block enforces that exclusivity.

Parameters:
- pWEIGHT_DATA_WIDTH, 64, width of one weight word (one bank entry).
- pWEIGHT_BASE_ADDR, 'h4000_0000, address of kernel row 0 on the RAM write port.
- pKERNEL_NUM, 1024, rows per bank.
- pULTRA_RAM_NUM, 8, number of banks; one kernel row = pULTRA_RAM_NUM words.
- pOUT_FIFO_DEPTH, 4, output row FIFO depth; must be >= 3 for full-rate streaming.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse; begins a load from IDLE.
- load_len  in  $clog2(pKERNEL_NUM)+1  rows to load, sampled at load_start.
- s_wvalid  in  1  weight beat valid.
- s_wready  out  1  weight beat accepted.
- s_wdata  in  pWEIGHT_DATA_WIDTH  weight beat.
- rd_start  in  1  one-cycle pulse; begins a read from IDLE.
- rd_base  in  $clog2(pKERNEL_NUM)  first row to read.
- rd_len  in  $clog2(pKERNEL_NUM)+1  rows to read.
- wr_en  out  1  RAM write enable.
- weight_addr  out  32  RAM write address.
- weight_data  out  pWEIGHT_DATA_WIDTH  RAM write data.
- kernel_addr  out  $clog2(pKERNEL_NUM)  RAM read address.
- kernel_data  in  pWEIGHT_DATA_WIDTH*pULTRA_RAM_NUM  RAM read data; valid 1 cycle after kernel_addr.
- m_kvalid  out  1  output row valid.
- m_kready  in  1  output row ready.
- m_kdata  out  pWEIGHT_DATA_WIDTH*pULTRA_RAM_NUM  output row.
- m_klast  out  1  marks the final row of a read.
- busy  out  1  high in LOAD, READ or DRAIN.
- done  out  1  one-cycle pulse when a load or read completes.
- err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (async assert, sync deassert): state IDLE; all outputs 0; weight_addr = pWEIGHT_BASE_ADDR; counters and FIFO cleared. The system reset also resets the RAM so its bank pointer is 0.
- FSM states: IDLE, LOAD, READ, DRAIN.
- IDLE start validation:
  - load_start with load_len == 0 or load_len > pKERNEL_NUM -> err pulse next cycle, stay IDLE.
  - rd_start with rd_len == 0 or rd_base + rd_len > pKERNEL_NUM (compare at $clog2(pKERNEL_NUM)+2 bits) -> err pulse next cycle, stay IDLE.
  - Both starts in the same cycle: load wins; rd_start is dropped silently.
  - Starts outside IDLE are ignored, with no err.
- LOAD:
  - s_wready = 1.
  - Each accepted beat drives registered wr_en = 1 on the next cycle, with weight_data = beat and weight_addr = pWEIGHT_BASE_ADDR + row.
  - bank_cnt counts 0..pULTRA_RAM_NUM-1; row increments when bank_cnt wraps.
  - The same address is therefore presented pULTRA_RAM_NUM times, once per bank in bank order. This matches the RAM's auto-advancing bank pointer.
  - Gaps in s_wvalid produce wr_en = 0 cycles; bank_cnt holds across gaps.
  - After load_len*pULTRA_RAM_NUM beats: s_wready drops the same cycle the last beat is accepted; the last wr_en follows; done pulses with it; return to IDLE.
  - Loads always end on a bank-count boundary, so the RAM bank pointer is 0 on exit.
- READ:
  - kernel_addr is registered and starts at rd_base.
  - An issue advances kernel_addr and marks a 2-stage in-flight pipe: RAM read, then FIFO capture.
  - Issue only when FIFO occupancy + in-flight < pOUT_FIFO_DEPTH.
  - Captured rows enter the FIFO; m_kvalid = FIFO not empty.
  - m_klast accompanies row index rd_len-1.
  - After the last issue, go to DRAIN.
  - wr_en = 0 throughout READ and DRAIN.
- Timing with m_kready held at 1:
  - rd_start at cycle 0.
  - kernel_addr = rd_base at cycle 1.
  - m_kvalid first high at cycle 3.
  - One row per cycle afterwards.
- DRAIN: wait for the m_kvalid & m_kready & m_klast handshake; done pulses that cycle; go to IDLE.
- Output stability: m_kdata, m_klast and m_kvalid must not change while m_kvalid & !m_kready.
- Reset mid-operation: immediate abort to IDLE; FIFO contents discarded; no done pulse.

Decomposition:
- Package kernel_ram_ctrl_pkg holds:
  - state enum (IDLE, LOAD, READ, DRAIN);
  - localparams ROW_W = pWEIGHT_DATA_WIDTH*pULTRA_RAM_NUM, KADDR_W = $clog2(pKERNEL_NUM), BANK_W = $clog2(pULTRA_RAM_NUM).
- One sub-module, kernel_row_fifo: synchronous, pOUT_FIFO_DEPTH entries, ROW_W wide, with occupancy output and same-cycle push/pop.

Test Plan:
- Load: load_len = 2, 16 consecutive beats D0..D15 -> wr_en on 16 cycles. Beats 0–7 at weight_addr = 'h4000_0000; beats 8–15 at 'h4000_0001. weight_data = D0..D15 in order. done coincides with the last wr_en.
- Load with s_wvalid toggling 1/0 for 8 beats -> wr_en mirrors each accept one cycle later; weight_addr constant at base; bank order unbroken.
- Read: rd_base = 5, rd_len = 4, m_kready = 1 -> kernel_addr 5, 6, 7, 8 on cycles 1–4; m_kvalid on cycles 3–6 with rows 5–8; m_klast on row 8; done on cycle 6.
- Backpressure: rd_len = 10, m_kready random at 50% -> all rows appear in order exactly once; FIFO occupancy never exceeds 4; data stable while stalled.
- Errors: rd_base = 1020, rd_len = 5 -> err pulse, busy stays 0. load_len = 0 -> err pulse. load_start and rd_start together -> LOAD entered, no err.
- Reset: rst_n asserted mid-READ after 2 rows delivered -> m_kvalid = 0 immediately, no done. A fresh read after reset returns correct data.
